// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit.
// M-extension op encodings and the controller state set.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } muldiv_state_t;

    function automatic logic op_a_signed(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV)  || (op == OP_REM);
    endfunction

    function automatic logic op_b_signed(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core controller and muldiv_unit.
// master drives the request side, slave is the unit itself.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            ready;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            illegal;

    modport master (
        output start, kill, funct3, op_a, op_b,
        input  ready, busy, done, result, illegal
    );

    modport slave (
        input  start, kill, funct3, op_a, op_b,
        output ready, busy, done, result, illegal
    );
endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate, used for operand magnitudes
// and for the final sign fix-up of product, quotient and remainder.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] val,
    output logic [W-1:0] res
);
    assign res = neg ? (~val + W'(1)) : val;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit, one bit per cycle.
// Define MULDIV_DIV_EN to build DIV/DIVU/REM/REMU; otherwise they flag illegal.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    muldiv_state_t state, state_nxt;
    muldiv_op_t    op, op_in;

    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mcand;
    logic              neg_q;
    logic [XLEN-1:0]   result_q;
    logic              illegal_q;

    logic              accept;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              fast, fast_ill;
    logic [XLEN-1:0]   fast_res;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_res;

    assign op_in  = muldiv_op_t'(bus.funct3);
    assign accept = (state == S_IDLE) && bus.start && !bus.kill;
    assign neg_a  = op_a_signed(op_in) && bus.op_a[XLEN-1];
    assign neg_b  = op_b_signed(op_in) && bus.op_b[XLEN-1];

    muldiv_signfix #(.W(XLEN)) u_abs_a (
        .neg (neg_a),
        .val (bus.op_a),
        .res (a_mag)
    );

    muldiv_signfix #(.W(XLEN)) u_abs_b (
        .neg (neg_b),
        .val (bus.op_b),
        .res (b_mag)
    );

    muldiv_signfix #(.W(2*XLEN)) u_fix_p (
        .neg (neg_q),
        .val (prod),
        .res (prod_fix)
    );

    // Shift-add: the carry bit of the upper half rides into the shift.
    assign mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} +
                     (prod[0] ? {1'b0, mcand} : '0);

`ifdef MULDIV_DIV_EN
    logic [XLEN-1:0] quot;
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] divisor;
    logic            neg_r;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [XLEN-1:0] quot_fix;
    logic [XLEN-1:0] rem_fix;
    logic            div_zero;
    logic            div_ovf;

    assign div_shift = {rem[XLEN-1:0], quot[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, divisor};

    assign div_zero = (bus.op_b == '0);
    assign div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                      (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (bus.op_b == '1);

    muldiv_signfix #(.W(XLEN)) u_fix_q (
        .neg (neg_q),
        .val (quot),
        .res (quot_fix)
    );

    muldiv_signfix #(.W(XLEN)) u_fix_r (
        .neg (neg_r),
        .val (rem[XLEN-1:0]),
        .res (rem_fix)
    );

    always_comb begin
        fast     = 1'b0;
        fast_ill = 1'b0;
        fast_res = '0;
        if (op_in[2]) begin
            if (div_zero) begin
                fast     = 1'b1;
                fast_res = bus.funct3[1] ? bus.op_a : '1;
            end else if (div_ovf) begin
                fast     = 1'b1;
                fast_res = bus.funct3[1] ? '0 : bus.op_a;
            end
        end
    end
`else
    always_comb begin
        fast     = op_in[2];
        fast_ill = op_in[2];
        fast_res = '0;
    end
`endif

    always_comb begin
        fix_res = '0;
        unique case (op)
            OP_MUL:    fix_res = prod_fix[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
            OP_DIV,
            OP_DIVU:   fix_res = quot_fix;
            OP_REM,
            OP_REMU:   fix_res = rem_fix;
`endif
            default:   fix_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (accept) state_nxt = fast ? S_DONE : S_CALC;
            S_CALC: if (cnt == LAST) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (bus.kill) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op        <= OP_MUL;
            cnt       <= '0;
            prod      <= '0;
            mcand     <= '0;
            neg_q     <= 1'b0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                op        <= op_in;
                cnt       <= '0;
                mcand     <= a_mag;
                prod      <= {{XLEN{1'b0}}, b_mag};
                neg_q     <= neg_a ^ neg_b;
                illegal_q <= fast_ill;
                if (fast) result_q <= fast_res;
            end
            if (state == S_CALC) begin
                cnt  <= cnt + CNT_W'(1);
                prod <= {mul_sum, prod[XLEN-1:1]};
            end
            if ((state == S_FIX) && !bus.kill) result_q <= fix_res;
        end
    end

`ifdef MULDIV_DIV_EN
    // Restoring division: keep the trial difference only if it did not borrow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quot    <= '0;
            rem     <= '0;
            divisor <= '0;
            neg_r   <= 1'b0;
        end else if (accept) begin
            quot    <= a_mag;
            rem     <= '0;
            divisor <= b_mag;
            neg_r   <= neg_a;
        end else if ((state == S_CALC) && op[2]) begin
            if (!div_diff[XLEN]) begin
                rem  <= div_diff;
                quot <= {quot[XLEN-2:0], 1'b1};
            end else begin
                rem  <= div_shift;
                quot <= {quot[XLEN-2:0], 1'b0};
            end
        end
    end
`endif

    assign bus.ready   = (state == S_IDLE);
    assign bus.busy    = (state == S_CALC) || (state == S_FIX);
    assign bus.done    = (state == S_DONE);
    assign bus.result  = result_q;
    assign bus.illegal = (state == S_DONE) && illegal_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
// Expectations follow MULDIV_DIV_EN the same way the design does.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic clk;
    logic reset;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] last_exp = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          output logic ill,
                                          output bit fast);
        logic [63:0] p;
        longint      sp;
        logic [31:0] r;
        ill  = 1'b0;
        fast = 1'b0;
        r    = '0;
        p    = '0;
        sp   = 0;
        if (!f[2]) begin
            case (f)
                3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
                3'd1: begin
                    sp = longint'(signed'(a)) * longint'(signed'(b));
                    p = sp; r = p[63:32];
                end
                3'd2: begin
                    sp = longint'(signed'(a)) * longint'({32'b0, b});
                    p = sp; r = p[63:32];
                end
                default: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            endcase
        end else begin
`ifdef MULDIV_DIV_EN
            if (b == 32'h0) begin
                fast = 1'b1;
                r = f[1] ? a : 32'hFFFF_FFFF;
            end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                fast = 1'b1;
                r = f[1] ? 32'h0 : a;
            end else begin
                case (f)
                    3'd4: r = $signed(a) / $signed(b);
                    3'd5: r = a / b;
                    3'd6: r = $signed(a) % $signed(b);
                    default: r = a % b;
                endcase
            end
`else
            fast = 1'b1;
            ill  = 1'b1;
            r    = '0;
`endif
        end
        return r;
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit hold,
                          output logic [31:0] res);
        logic [31:0] exp_r;
        logic        exp_ill;
        bit          exp_fast;
        int          n;
        int          busy_n;
        bit          seen;
        exp_r = model(f, a, b, exp_ill, exp_fast);
        @(negedge clk);
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            bus.funct3 = 3'($urandom);
            bus.op_a   = $urandom;
            bus.op_b   = $urandom;
        end else begin
            bus.start = 1'b0;
        end
        n = 0;
        busy_n = 0;
        seen = 1'b0;
        while (n <= 100) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        chk($sformatf("done_seen f=%0d", f), 64'(seen), 64'd1);
        chk($sformatf("latency f=%0d", f), 64'(n),
            exp_fast ? 64'd0 : 64'(XLEN + 1));
        chk($sformatf("busy_cycles f=%0d", f), 64'(busy_n),
            exp_fast ? 64'd0 : 64'(XLEN + 1));
        chk($sformatf("result f=%0d a=%h b=%h", f, a, b),
            64'(bus.result), 64'(exp_r));
        chk($sformatf("illegal f=%0d", f), 64'(bus.illegal), 64'(exp_ill));
        res = bus.result;
        last_exp = exp_r;
        @(negedge clk);
        chk("done_pulse_end", 64'(bus.done), 64'd0);
        chk("ready_after", 64'(bus.ready), 64'd1);
    endtask

    initial begin
        logic [31:0] r;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          d;

        reset = 1'b1;
        bus.start  = 1'b0;
        bus.kill   = 1'b0;
        bus.funct3 = '0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(bus.ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_illegal", 64'(bus.illegal), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        reset = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, r);
        chk("mul_7xm3", 64'(r), 64'hFFFF_FFEB);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, r);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, r);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, r);
        run_op(3'd5, 32'd100, 32'd7, 1'b0, r);
        run_op(3'd7, 32'd100, 32'd7, 1'b0, r);
        run_op(3'd4, 32'd5, 32'd0, 1'b0, r);
        run_op(3'd6, 32'd5, 32'd0, 1'b0, r);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, r);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, r);
        run_op(3'd5, 32'd9, 32'd3, 1'b0, r);

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            run_op(f, a, b, 1'b0, r);
        end

        run_op(3'd1, 32'h1234_5678, 32'h8765_4321, 1'b1, r);
        run_op(3'd0, 32'hDEAD_BEEF, 32'h0000_0101, 1'b0, r);

        @(negedge clk);
        bus.funct3 = 3'd0;
        bus.op_a   = 32'h0BAD_F00D;
        bus.op_b   = 32'h0000_1234;
        bus.start  = 1'b1;
        bus.kill   = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.kill   = 1'b0;
        chk("start_kill_ready", 64'(bus.ready), 64'd1);
        chk("start_kill_busy", 64'(bus.busy), 64'd0);

        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        chk("kill_ready", 64'(bus.ready), 64'd1);
        chk("kill_busy", 64'(bus.busy), 64'd0);
        chk("kill_result", 64'(bus.result), 64'(last_exp));
        d = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) d++;
        end
        chk("kill_no_done", 64'(d), 64'd0);

`ifdef MULDIV_DIV_EN
        bus.funct3 = 3'd4;
        bus.op_a   = 32'd1000;
        bus.op_b   = 32'd7;
`else
        bus.funct3 = 3'd0;
        bus.op_a   = 32'd1000;
        bus.op_b   = 32'd7;
`endif
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", 64'(bus.busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_ready", 64'(bus.ready), 64'd1);
        chk("async_busy", 64'(bus.busy), 64'd0);
        chk("async_done", 64'(bus.done), 64'd0);
        chk("async_result", 64'(bus.result), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
